seg_scan_display: RTL

//  Consumer of the stopwatch BCD time bus. Drives a 4-digit, common-anode, time-multiplexed
//  7-segment display: SS.cc, with the decimal point after the seconds-units digit.

---
 rtl/seg_scan_display_if.sv | 28 ++
 rtl/seg_scan_display.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display_if
// Description : Stopwatch BCD time bus plus the 4-digit display pin group.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_display_if;
    logic [2:0] time_sec_h;
    logic [3:0] time_sec_l;
    logic [3:0] time_msec_h;
    logic [3:0] time_msec_l;
    logic       time_out;
    logic       pause;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output time_sec_h, time_sec_l, time_msec_h, time_msec_l, time_out, pause,
        input  an, seg, dp
    );

    modport slave (
        input  time_sec_h, time_sec_l, time_msec_h, time_msec_l, time_out, pause,
        output an, seg, dp
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Multiplexed 4-digit common-anode SS.cc display driver with
//               per-frame snapshot, guard blanking and time-out blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display #(
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD_CYC    = 500,
    parameter int BLINK_FRAMES = 64,
    parameter bit LZB          = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_display_if.slave bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FC_W  = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    logic [2:0]       sh_sec_h_q, sh_sec_h_d;
    logic [3:0]       sh_sec_l_q, sh_sec_l_d;
    logic [3:0]       sh_msec_h_q, sh_msec_h_d;
    logic [3:0]       sh_msec_l_q, sh_msec_l_d;
    logic             sh_time_out_q, sh_time_out_d;
    logic             sh_pause_q, sh_pause_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       digit;
    logic             snap;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_ph_d    = blink_ph_q;
        sh_sec_h_d    = sh_sec_h_q;
        sh_sec_l_d    = sh_sec_l_q;
        sh_msec_h_d   = sh_msec_h_q;
        sh_msec_l_d   = sh_msec_l_q;
        sh_time_out_d = sh_time_out_q;
        sh_pause_d    = sh_pause_q;
        snap          = (cnt_q == '0) && (idx_q == 2'd0);

        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        if (snap) begin
            sh_sec_h_d    = bus.time_sec_h;
            sh_sec_l_d    = bus.time_sec_l;
            sh_msec_h_d   = bus.time_msec_h;
            sh_msec_l_d   = bus.time_msec_l;
            sh_time_out_d = bus.time_out;
            sh_pause_d    = bus.pause;
            // Blink phase advances on the time_out of the frame just finished.
            if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end

        if (!sh_time_out_q) begin
            frame_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end

        case (idx_q)
            2'd0:    digit = sh_msec_l_q;
            2'd1:    digit = sh_msec_h_q;
            2'd2:    digit = sh_sec_l_q;
            default: digit = {1'b0, sh_sec_h_q};
        endcase

        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if ((cnt_q >= CNT_W'(GUARD_CYC)) && !(sh_time_out_q && blink_ph_q)) begin
            if (!((idx_q == 2'd3) && LZB && (sh_sec_h_q == 3'd0))) begin
                an_d  = ~(4'b0001 << idx_q);
                seg_d = decode(digit);
            end
            if ((idx_q == 2'd2) || ((idx_q == 2'd0) && sh_pause_q))
                dp_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            frame_cnt_q   <= '0;
            blink_ph_q    <= 1'b0;
            sh_sec_h_q    <= 3'd0;
            sh_sec_l_q    <= 4'd0;
            sh_msec_h_q   <= 4'd0;
            sh_msec_l_q   <= 4'd0;
            sh_time_out_q <= 1'b0;
            sh_pause_q    <= 1'b0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_ph_q    <= blink_ph_d;
            sh_sec_h_q    <= sh_sec_h_d;
            sh_sec_l_q    <= sh_sec_l_d;
            sh_msec_h_q   <= sh_msec_h_d;
            sh_msec_l_q   <= sh_msec_l_d;
            sh_time_out_q <= sh_time_out_d;
            sh_pause_q    <= sh_pause_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule
`default_nettype wire
